// File: rtl/pwm_fade_sequencer_if.sv
// rtl/pwm_fade_sequencer_if.sv - control and status bundle for the PWM fade sequencer
interface pwm_fade_sequencer_if #(
    parameter int DUTY_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 16,
    parameter int HOLD_WIDTH     = 8
);
    logic                      enable;
    logic                      one_shot;
    logic [PRESCALE_WIDTH-1:0] step_div;
    logic [DUTY_WIDTH-1:0]     duty_min;
    logic [DUTY_WIDTH-1:0]     duty_max;
    logic [HOLD_WIDTH-1:0]     hold_ticks;
    logic [DUTY_WIDTH-1:0]     duty;
    logic [2:0]                state;
    logic                      busy;
    logic                      cycle_done;

    modport master (
        output enable, one_shot, step_div, duty_min, duty_max, hold_ticks,
        input  duty, state, busy, cycle_done
    );

    modport slave (
        input  enable, one_shot, step_div, duty_min, duty_max, hold_ticks,
        output duty, state, busy, cycle_done
    );
endinterface

// File: rtl/pwm_fade_sequencer.sv
// rtl/pwm_fade_sequencer.sv - breathing-fade duty sequencer feeding the PWM generator
module pwm_fade_sequencer #(
    parameter int DUTY_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 16,
    parameter int HOLD_WIDTH     = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    pwm_fade_sequencer_if.slave    bus
);
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RAMP_UP   = 3'd1,
        S_HOLD_HIGH = 3'd2,
        S_RAMP_DOWN = 3'd3,
        S_HOLD_LOW  = 3'd4
    } state_t;

    localparam logic [PRESCALE_WIDTH-1:0] PRE_ONE  = 1;
    localparam logic [HOLD_WIDTH-1:0]     HOLD_ONE = 1;
    localparam logic [DUTY_WIDTH-1:0]     DUTY_ONE = 1;

    state_t                    r_state;
    logic [DUTY_WIDTH-1:0]     r_duty;
    logic [PRESCALE_WIDTH-1:0] r_pre;
    logic [HOLD_WIDTH-1:0]     r_hold_cnt;
    logic [DUTY_WIDTH-1:0]     r_min_l;
    logic [DUTY_WIDTH-1:0]     r_max_l;
    logic [HOLD_WIDTH-1:0]     r_hold_l;
    logic [PRESCALE_WIDTH-1:0] r_div_l;
    logic                      r_one_shot_l;
    logic                      r_busy;
    logic                      r_cycle_done;

    logic                      w_swap;
    logic [DUTY_WIDTH-1:0]     w_min_in;
    logic [DUTY_WIDTH-1:0]     w_max_in;
    logic                      w_tick;
    logic                      w_hold_done;
    logic                      w_low_end;
    logic                      w_start;

    // Limits are normalised before latching so the ramps always run low..high
    assign w_swap      = bus.duty_min > bus.duty_max;
    assign w_min_in    = w_swap ? bus.duty_max : bus.duty_min;
    assign w_max_in    = w_swap ? bus.duty_min : bus.duty_max;
    assign w_tick      = (r_pre == r_div_l);
    assign w_hold_done = (r_hold_cnt == r_hold_l);
    assign w_low_end   = (r_state == S_HOLD_LOW) && w_tick && w_hold_done;
    assign w_start     = ((r_state == S_IDLE) && bus.enable) ||
                         (w_low_end && bus.enable && !r_one_shot_l);

    assign bus.duty       = r_duty;
    assign bus.state      = r_state;
    assign bus.busy       = r_busy;
    assign bus.cycle_done = r_cycle_done;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_duty       <= '0;
            r_pre        <= '0;
            r_hold_cnt   <= '0;
            r_min_l      <= '0;
            r_max_l      <= '0;
            r_hold_l     <= '0;
            r_div_l      <= '0;
            r_one_shot_l <= 1'b0;
            r_busy       <= 1'b0;
            r_cycle_done <= 1'b0;
        end else begin
            r_cycle_done <= w_low_end;
            if (w_start) begin
                // Every RAMP_UP entry snapshots the config, so mid-cycle edits wait
                r_min_l      <= w_min_in;
                r_max_l      <= w_max_in;
                r_hold_l     <= bus.hold_ticks;
                r_div_l      <= bus.step_div;
                r_one_shot_l <= bus.one_shot;
                r_duty       <= w_min_in;
                r_pre        <= '0;
                r_hold_cnt   <= '0;
                r_busy       <= 1'b1;
                r_state      <= S_RAMP_UP;
            end else if (r_state == S_IDLE) begin
                r_duty <= '0;
                r_pre  <= '0;
                r_busy <= 1'b0;
            end else begin
                r_pre <= w_tick ? '0 : r_pre + PRE_ONE;
                if (w_tick) begin
                    case (r_state)
                        S_RAMP_UP: begin
                            if (r_duty == r_max_l) begin
                                r_state    <= S_HOLD_HIGH;
                                r_hold_cnt <= '0;
                            end else begin
                                r_duty <= r_duty + DUTY_ONE;
                            end
                        end
                        S_HOLD_HIGH: begin
                            if (w_hold_done) r_state <= S_RAMP_DOWN;
                            else             r_hold_cnt <= r_hold_cnt + HOLD_ONE;
                        end
                        S_RAMP_DOWN: begin
                            if (r_duty == r_min_l) begin
                                r_state    <= S_HOLD_LOW;
                                r_hold_cnt <= '0;
                            end else begin
                                r_duty <= r_duty - DUTY_ONE;
                            end
                        end
                        S_HOLD_LOW: begin
                            if (w_hold_done) begin
                                r_state <= S_IDLE;
                                r_duty  <= '0;
                                r_busy  <= 1'b0;
                            end else begin
                                r_hold_cnt <= r_hold_cnt + HOLD_ONE;
                            end
                        end
                        default: begin
                            r_state <= S_IDLE;
                            r_duty  <= '0;
                            r_busy  <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end
endmodule
